fir_ctrl: RTL and testbench

FIR_CTRL -- requirements
Module: fir_ctrl

---
 rtl/fir_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fir_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// FIR controller: loads a coefficient set into the MAC core, then sequences
// one push/multiply/accumulate/wait pass per accepted sample and hands the
// core result downstream with a valid/ready handshake.
module fir_ctrl #(
    parameter int unsigned NTAPS    = 64,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        coef_loaded,
    output logic [15:0] core_din,
    output logic [13:0] core_addr,
    output logic [1:0]  core_dload,
    output logic        core_cload,
    output logic        core_mul_en,
    output logic        core_acc_en,
    input  logic [31:0] core_dout
);

    localparam int unsigned IW = 6;
    localparam int unsigned WW = 8;
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
    localparam logic [WW-1:0] LAT_INIT = WW'(CORE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        LDCOEF,
        WAITS,
        PUSH,
        MUL,
        ACC,
        WAITR,
        OUT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cidx_q, cidx_d;
    logic [IW-1:0] sptr_q, sptr_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          coef_q, coef_d;
    logic [15:0]   sample_q, sample_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;

    // State and datapath registers, cleared asynchronously so any partial
    // load or pending result is discarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cidx_q      <= '0;
            sptr_q      <= '0;
            wcnt_q      <= '0;
            coef_q      <= 1'b0;
            sample_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cidx_q      <= cidx_d;
            sptr_q      <= sptr_d;
            wcnt_q      <= wcnt_d;
            coef_q      <= coef_d;
            sample_q    <= sample_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state logic plus the per-cycle core strobes decoded from state.
    always_comb begin
        state_d     = state_q;
        cidx_d      = cidx_q;
        sptr_d      = sptr_q;
        wcnt_d      = wcnt_q;
        coef_d      = coef_q;
        sample_d    = sample_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready    = 1'b0;
        core_din    = '0;
        core_addr   = '0;
        core_dload  = 2'b11;
        core_cload  = 1'b0;
        core_mul_en = 1'b0;
        core_acc_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LDCOEF;
                    cidx_d  = '0;
                    coef_d  = 1'b0;
                end
            end
            LDCOEF: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    core_cload = 1'b1;
                    core_din   = in_data;
                    core_addr  = {8'b0, cidx_q};
                    cidx_d     = IW'(cidx_q + IW'(1));
                    if (cidx_q == LAST_IDX) begin
                        state_d = WAITS;
                        coef_d  = 1'b1;
                        sptr_d  = '0;
                    end
                end
            end
            WAITS: begin
                in_ready = 1'b1;
                // An accepted sample takes priority over a reload request.
                if (in_valid) begin
                    sample_d = in_data;
                    state_d  = PUSH;
                end else if (cfg_start) begin
                    state_d = LDCOEF;
                    cidx_d  = '0;
                    coef_d  = 1'b0;
                end
            end
            PUSH: begin
                core_dload = 2'b00;
                core_din   = sample_q;
                core_addr  = {8'b0, sptr_q};
                sptr_d     = (sptr_q == LAST_IDX) ? '0 : IW'(sptr_q + IW'(1));
                state_d    = MUL;
            end
            MUL: begin
                core_mul_en = 1'b1;
                state_d     = ACC;
            end
            ACC: begin
                core_acc_en = 1'b1;
                wcnt_d      = LAT_INIT;
                state_d     = WAITR;
            end
            WAITR: begin
                wcnt_d = (wcnt_q == '0) ? '0 : WW'(wcnt_q - WW'(1));
                // Capture on the cycle the counter reaches zero, when the
                // core result has become valid.
                if (wcnt_q <= WW'(1)) begin
                    out_data_d  = core_dout;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = WAITS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign coef_loaded = coef_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed testbench for fir_ctrl with a behavioural core whose output
// tracks the cycle count, so a capture taken on the wrong cycle is visible.
module tb_fir_ctrl;

    localparam int NTAPS    = 64;
    localparam int CORE_LAT = 2;
    localparam int PERIOD   = 4 + CORE_LAT + 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        coef_loaded;
    logic [15:0] core_din;
    logic [13:0] core_addr;
    logic [1:0]  core_dload;
    logic        core_cload;
    logic        core_mul_en;
    logic        core_acc_en;
    logic [31:0] core_dout;

    logic [15:0] cyc = '0;
    int          total = 0;
    int          bad = 0;
    int          exp_sptr = 0;

    fir_ctrl #(.NTAPS(NTAPS), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .resetn(resetn), .cfg_start(cfg_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_loaded(coef_loaded), .core_din(core_din), .core_addr(core_addr),
        .core_dload(core_dload), .core_cload(core_cload),
        .core_mul_en(core_mul_en), .core_acc_en(core_acc_en),
        .core_dout(core_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;
    assign core_dout = {16'hA5A5, cyc};

    // Strobe exclusivity and idle-bus checks every cycle.
    always @(negedge clk) begin
        int n;
        #2;
        n = int'(core_cload) + int'(core_mul_en) + int'(core_acc_en) + int'(core_dload == 2'b00);
        total++;
        if (n > 1 || (n == 0 && (core_din !== 16'h0 || core_addr !== 14'h0)) || core_addr[13:6] !== 8'h0) begin
            bad++;
            $display("FAIL strobe_excl t=%0t strobes=%0d din=%h addr=%h required <=1 strobe, idle bus 0", $time, n, core_din, core_addr);
        end
    end

    task automatic test_reset();
        resetn = 1'b0; cfg_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || coef_loaded !== 1'b0) begin
            bad++; $display("FAIL reset_ctl got rdy=%b ov=%b cl=%b required 0/0/0", in_ready, out_valid, coef_loaded);
        end
        total++;
        if (out_data !== 32'h0 || core_din !== 16'h0 || core_addr !== 14'h0) begin
            bad++; $display("FAIL reset_data got od=%h din=%h addr=%h required 0", out_data, core_din, core_addr);
        end
        total++;
        if (core_dload !== 2'b11 || core_cload !== 1'b0 || core_mul_en !== 1'b0 || core_acc_en !== 1'b0) begin
            bad++; $display("FAIL reset_strobes got dload=%b cl=%b mul=%b acc=%b required 11/0/0/0", core_dload, core_cload, core_mul_en, core_acc_en);
        end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk); in_valid = 1'b1; #1;
        total++;
        if (in_ready !== 1'b0 || core_cload !== 1'b0) begin
            bad++; $display("FAIL idle_no_accept got rdy=%b cload=%b required 0/0", in_ready, core_cload);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load();
        @(negedge clk); cfg_start = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            @(negedge clk); cfg_start = 1'b0; in_valid = 1'b1; in_data = 16'(i); #1;
            total++;
            if (core_cload !== 1'b1 || core_addr !== 14'(i) || core_din !== 16'(i) || in_ready !== 1'b1) begin
                bad++; $display("FAIL load_beat%0d got cl=%b addr=%0d din=%0d rdy=%b required 1/%0d/%0d/1", i, core_cload, core_addr, core_din, in_ready, i, i);
            end
            total++;
            if (coef_loaded !== 1'b0) begin
                bad++; $display("FAIL load_coef_early beat%0d got %b required 0", i, coef_loaded);
            end
        end
        @(negedge clk); in_valid = 1'b0; #1;
        total++;
        if (coef_loaded !== 1'b1 || in_ready !== 1'b1 || core_cload !== 1'b0) begin
            bad++; $display("FAIL load_done got cl=%b rdy=%b cload=%b required 1/1/0", coef_loaded, in_ready, core_cload);
        end
        exp_sptr = 0;
    endtask

    // One sample pass; the first call cycle is the accept cycle in WAITS.
    task automatic run_sample(input logic [15:0] d, input bit cfg_same, input bit cfg_waitr,
                              input int hold, output int acc_at);
        logic [31:0] exp;
        @(negedge clk); in_valid = 1'b1; in_data = d; cfg_start = cfg_same; out_ready = (hold == 0); #1;
        acc_at = int'(cyc);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL accept got rdy=%b ov=%b required 1/0", in_ready, out_valid);
        end
        @(negedge clk); in_valid = 1'b0; cfg_start = 1'b0; #1;
        total++;
        if (core_dload !== 2'b00 || core_addr !== 14'(exp_sptr) || core_din !== d || in_ready !== 1'b0 || coef_loaded !== 1'b1) begin
            bad++; $display("FAIL push got dload=%b addr=%0d din=%h rdy=%b cl=%b required 00/%0d/%h/0/1", core_dload, core_addr, core_din, in_ready, coef_loaded, exp_sptr, d);
        end
        exp_sptr = (exp_sptr + 1) % NTAPS;
        @(negedge clk); #1;
        total++;
        if (core_mul_en !== 1'b1 || core_dload !== 2'b11 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mul got mul=%b dload=%b rdy=%b required 1/11/0", core_mul_en, core_dload, in_ready);
        end
        @(negedge clk); #1;
        total++;
        if (core_acc_en !== 1'b1 || core_mul_en !== 1'b0) begin
            bad++; $display("FAIL acc got acc=%b mul=%b required 1/0", core_acc_en, core_mul_en);
        end
        exp = {16'hA5A5, 16'(int'(cyc) + CORE_LAT)};
        for (int k = 0; k < CORE_LAT; k++) begin
            @(negedge clk); cfg_start = (cfg_waitr && k == 0); #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad++; $display("FAIL waitr%0d got ov=%b rdy=%b required 0/0", k, out_valid, in_ready);
            end
        end
        @(negedge clk); cfg_start = 1'b0; #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== exp || coef_loaded !== 1'b1) begin
            bad++; $display("FAIL result got ov=%b od=%h cl=%b required 1/%h/1", out_valid, out_data, coef_loaded, exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); out_ready = (h == hold - 1); #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                bad++; $display("FAIL hold%0d got ov=%b od=%h rdy=%b required 1/%h/0", h, out_valid, out_data, in_ready, exp);
            end
        end
    endtask

    task automatic test_single();
        int t;
        run_sample(16'h0800, 1'b0, 1'b0, 0, t);
    endtask

    task automatic test_stream();
        int t0, t;
        test_load();
        run_sample(16'h0800, 1'b0, 1'b0, 0, t0);
        for (int i = 1; i <= NTAPS; i++) run_sample(16'(i * 257), 1'b0, 1'b0, 0, t);
        total++;
        if (t - t0 != NTAPS * PERIOD) begin
            bad++; $display("FAIL throughput got %0d cycles required %0d", t - t0, NTAPS * PERIOD);
        end
    endtask

    task automatic test_backpressure();
        int t;
        run_sample(16'h1234, 1'b0, 1'b0, 10, t);
        run_sample(16'h4321, 1'b0, 1'b0, 0, t);
    endtask

    task automatic test_collide();
        int t;
        run_sample(16'h7FFF, 1'b1, 1'b0, 0, t);
        run_sample(16'h8001, 1'b0, 1'b1, 0, t);
    endtask

    task automatic test_midload_reset();
        int t;
        @(negedge clk); cfg_start = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); cfg_start = 1'b0; in_valid = 1'b1; in_data = 16'(i);
        end
        @(negedge clk); in_data = 16'd30; #1;
        total++;
        if (core_cload !== 1'b1 || core_addr !== 14'd30) begin
            bad++; $display("FAIL beat30 got cl=%b addr=%0d required 1/30", core_cload, core_addr);
        end
        #2 resetn = 1'b0; #1;
        total++;
        if (core_cload !== 1'b0 || core_addr !== 14'h0 || core_din !== 16'h0 || in_ready !== 1'b0 || coef_loaded !== 1'b0 || core_dload !== 2'b11 || out_valid !== 1'b0) begin
            bad++; $display("FAIL async_reset got cl=%b addr=%h din=%h rdy=%b coef=%b dload=%b ov=%b required reset values",
                            core_cload, core_addr, core_din, in_ready, coef_loaded, core_dload, out_valid);
        end
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (in_ready !== 1'b0 || core_cload !== 1'b0 || coef_loaded !== 1'b0 || core_dload !== 2'b11) begin
                bad++; $display("FAIL post_reset%0d got rdy=%b cl=%b coef=%b dload=%b required 0/0/0/11", i, in_ready, core_cload, coef_loaded, core_dload);
            end
        end
        in_valid = 1'b0;
        test_load();
        run_sample(16'h0400, 1'b0, 1'b0, 0, t);
    endtask

    initial begin
        test_reset();
        test_load();
        test_single();
        test_stream();
        test_backpressure();
        test_collide();
        test_midload_reset();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
